gate_vector_seq: RTL and testbench

Upstream stimulus/compare stage of the IC tester. On `start`, it drives the four 2-input vectors (AB = 00, 01, 10, 11) onto up to six gates of the IC under test in parallel. For each vector it waits a settle time, samples the gate outputs and compares them to the expected function. When the run completes, it presents per-gate `pass`/`fail` flags and the `icg` qualifier, which the pass/fail counter downstream consumes combinationally.

---
 rtl/gate_vector_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_gate_vector_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_seq.sv
// gate_vector_seq: IC tester stimulus/compare stage.
// Drives the four 2-input vectors (AB = 00, 01, 10, 11) onto up to NUM_GATES
// gate lanes in parallel. After each vector has settled, the gate outputs are
// sampled and compared with the expected function. When the run ends, the
// per-lane pass/fail flags are presented, qualified by icg.
//
// Optional build macro: GVS_INPUT_SYNC_EN
//   When defined, dut_y_i passes through a 2-flop synchronizer. SETTLE is then
//   stretched by two cycles so that the synchronized copy has caught up with
//   the applied vector before it is compared.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for start_i
// SETTLE | vector applied, settle down-counter running
// SAMPLE | compare lane outputs, then step to the next vector or finish
// DONE   | results valid (icg_o=1) until the next accepted start_i
module gate_vector_seq #(
    parameter int NUM_GATES     = 6,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [2:0]           gate_type_i,
    input  logic [2:0]           gate_count_i,
    output logic [NUM_GATES-1:0] dut_a_o,
    output logic [NUM_GATES-1:0] dut_b_o,
    input  logic [NUM_GATES-1:0] dut_y_i,
    output logic [NUM_GATES-1:0] pass_o,
    output logic [NUM_GATES-1:0] fail_o,
    output logic                 icg_o,
    output logic                 busy_o,
    output logic [1:0]           vec_idx_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

`ifdef GVS_INPUT_SYNC_EN
    localparam logic [4:0] SETTLE_LOAD = 5'(SETTLE_CYCLES + 1);
`else
    localparam logic [4:0] SETTLE_LOAD = 5'(SETTLE_CYCLES - 1);
`endif

    localparam logic [2:0] MAX_COUNT = 3'(NUM_GATES);

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [2:0]           type_q, type_d;
    logic [NUM_GATES-1:0] mask_q, mask_d;
    logic [NUM_GATES-1:0] err_q, err_d;
    logic [NUM_GATES-1:0] a_q, a_d;
    logic [NUM_GATES-1:0] b_q, b_d;
    logic [NUM_GATES-1:0] pass_q, pass_d;
    logic [NUM_GATES-1:0] fail_q, fail_d;
    logic                 icg_q, icg_d;
    logic                 busy_q, busy_d;
    logic [1:0]           vec_q, vec_d;

    logic [2:0]           count_clamped;
    logic [NUM_GATES-1:0] mask_in;
    logic [NUM_GATES-1:0] y_cmp;
    logic [NUM_GATES-1:0] expected;
    logic [NUM_GATES-1:0] mismatch;
    logic [NUM_GATES-1:0] err_new;
    logic                 start_ok;

`ifdef GVS_INPUT_SYNC_EN
    logic [NUM_GATES-1:0] y_s1_q, y_s2_q;

    // Two-flop synchronizer for the asynchronous socket outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s1_q <= '0;
            y_s2_q <= '0;
        end else begin
            y_s1_q <= dut_y_i;
            y_s2_q <= y_s1_q;
        end
    end

    assign y_cmp = y_s2_q;
`else
    assign y_cmp = dut_y_i;
`endif

    // Clamp gate_count and build the active-lane mask for the next run.
    always_comb begin
        count_clamped = (gate_count_i > MAX_COUNT) ? MAX_COUNT : gate_count_i;
        mask_in = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            mask_in[i] = (i < int'(count_clamped));
        end
    end

    // Expected lane outputs for the vector currently on the pins.
    always_comb begin
        expected = '0;
        unique case (type_q)
            3'd0:    expected = a_q & b_q;
            3'd1:    expected = ~(a_q & b_q);
            3'd2:    expected = a_q | b_q;
            3'd3:    expected = ~(a_q | b_q);
            3'd4:    expected = a_q ^ b_q;
            3'd5:    expected = ~(a_q ^ b_q);
            3'd6:    expected = ~a_q;
            default: expected = '0;
        endcase
        // An invalid gate type can never pass, so every lane is flagged.
        mismatch = (type_q == 3'd7) ? '1 : (expected ^ y_cmp);
        err_new  = err_q | (mask_q & mismatch);
    end

    assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = SETTLE;
            SETTLE: begin
                if (mask_q == '0)     state_d = DONE;
                else if (cnt_q == '0) state_d = SAMPLE;
            end
            SAMPLE:  state_d = (vec_q == 2'd3) ? DONE : SETTLE;
            DONE:    if (start_i) state_d = SETTLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the counter, run context and registered outputs.
    always_comb begin
        cnt_d  = cnt_q;
        type_d = type_q;
        mask_d = mask_q;
        err_d  = err_q;
        a_d    = a_q;
        b_d    = b_q;
        pass_d = pass_q;
        fail_d = fail_q;
        icg_d  = icg_q;
        busy_d = busy_q;
        vec_d  = vec_q;
        if (start_ok) begin
            cnt_d  = SETTLE_LOAD;
            type_d = gate_type_i;
            mask_d = mask_in;
            err_d  = '0;
            a_d    = '0;
            b_d    = '0;
            pass_d = '0;
            fail_d = '0;
            icg_d  = 1'b0;
            busy_d = 1'b1;
            vec_d  = 2'd0;
        end else if (state_q == SETTLE) begin
            if (mask_q == '0) begin
                icg_d  = 1'b1;
                busy_d = 1'b0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 5'd1;
            end
        end else if (state_q == SAMPLE) begin
            err_d = err_new;
            if (vec_q != 2'd3) begin
                vec_d = vec_q + 2'd1;
                cnt_d = SETTLE_LOAD;
                a_d   = mask_q & {NUM_GATES{vec_d[1]}};
                b_d   = mask_q & {NUM_GATES{vec_d[0]}};
            end else begin
                pass_d = mask_q & ~err_new;
                fail_d = mask_q & err_new;
                icg_d  = 1'b1;
                busy_d = 1'b0;
                a_d    = '0;
                b_d    = '0;
            end
        end
    end

    // Datapath and output registers; all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            type_q <= '0;
            mask_q <= '0;
            err_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            pass_q <= '0;
            fail_q <= '0;
            icg_q  <= 1'b0;
            busy_q <= 1'b0;
            vec_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            type_q <= type_d;
            mask_q <= mask_d;
            err_q  <= err_d;
            a_q    <= a_d;
            b_q    <= b_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            icg_q  <= icg_d;
            busy_q <= busy_d;
            vec_q  <= vec_d;
        end
    end

    assign dut_a_o   = a_q;
    assign dut_b_o   = b_q;
    assign pass_o    = pass_q;
    assign fail_o    = fail_q;
    assign icg_o     = icg_q;
    assign busy_o    = busy_q;
    assign vec_idx_o = vec_q;

endmodule

// File: tb/tb_gate_vector_seq.sv
// Bench for gate_vector_seq: a socket model emulates the IC under test (its
// real gate function plus stuck-at faults per lane); the expected flags come
// from evaluating truth tables over all four vectors.
module tb_gate_vector_seq;

    localparam int NG = 6;
    localparam int S  = 4;
`ifdef GVS_INPUT_SYNC_EN
    localparam int SL = S + 2;
`else
    localparam int SL = S;
`endif
    localparam int STEP = SL + 1;
    localparam int LAT  = 4 * STEP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    gt = '0;
    logic [2:0]    gc = '0;
    logic [NG-1:0] dut_a, dut_b, dut_y, pass, fail;
    logic          icg, busy;
    logic [1:0]    vec;

    int            ic_type = 0;
    logic [NG-1:0] st0 = '0;
    logic [NG-1:0] st1 = '0;
    logic [3:0]    tt [0:7];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_vector_seq #(.NUM_GATES(NG), .SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .gate_type_i  (gt),
        .gate_count_i (gc),
        .dut_a_o      (dut_a),
        .dut_b_o      (dut_b),
        .dut_y_i      (dut_y),
        .pass_o       (pass),
        .fail_o       (fail),
        .icg_o        (icg),
        .busy_o       (busy),
        .vec_idx_o    (vec)
    );

    // Socket model: the real IC's function with optional stuck lanes.
    always_comb begin
        dut_y = '0;
        for (int i = 0; i < NG; i++) begin
            if (st0[i])      dut_y[i] = 1'b0;
            else if (st1[i]) dut_y[i] = 1'b1;
            else             dut_y[i] = tt[ic_type][{dut_a[i], dut_b[i]}];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, 32'(dut_a), 0);
        chk({tag, "_b"}, 32'(dut_b), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_fail"}, 32'(fail), 0);
        chk({tag, "_icg"}, 32'(icg), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_vec"}, 32'(vec), 0);
    endtask

    // One complete run; ign_at >= 0 pulses start at that cycle of the run.
    task automatic run(input int t, input int c, input int ict,
                       input logic [NG-1:0] s0, input logic [NG-1:0] s1,
                       input int ign_at);
        int            n, lat, k, v;
        logic [NG-1:0] m, ep, ef;
        logic          e, obs, want;
        n   = (c > NG) ? NG : c;
        m   = NG'((1 << n) - 1);
        lat = (n == 0) ? 1 : LAT;
        ep  = '0;
        ef  = '0;
        for (int i = 0; i < n; i++) begin
            e = 1'b0;
            for (v = 0; v < 4; v++) begin
                obs  = s0[i] ? 1'b0 : (s1[i] ? 1'b1 : tt[ict][v]);
                want = tt[t][v];
                if (t == 7 || obs != want) e = 1'b1;
            end
            ep[i] = ~e;
            ef[i] = e;
        end
        gt      = 3'(t);
        gc      = 3'(c);
        ic_type = ict;
        st0     = s0;
        st1     = s1;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (icg !== 1'b1 && k < lat + 10) begin
            chk("busy_run", 32'(busy), 1);
            chk("vec_idx", 32'(vec), 32'(k / STEP));
            chk("dut_a", 32'(dut_a), 32'(m & {NG{(((k / STEP) >> 1) & 1) == 1}}));
            chk("dut_b", 32'(dut_b), 32'(m & {NG{((k / STEP) & 1) == 1}}));
            if (k == ign_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            k++;
        end
        chk("latency", 32'(k), 32'(lat));
        chk("icg", 32'(icg), 1);
        chk("pass", 32'(pass), 32'(ep));
        chk("fail", 32'(fail), 32'(ef));
        chk("overlap", 32'(pass & fail), 0);
        chk("busy_done", 32'(busy), 0);
        chk("a_done", 32'(dut_a), 0);
        chk("b_done", 32'(dut_b), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("icg_hold", 32'(icg), 1);
        chk("pass_hold", 32'(pass), 32'(ep));
    endtask

    initial begin
        int t, c, ict, ign;
        logic [NG-1:0] s0, s1;
        // Truth tables indexed by {A,B}.
        tt[0] = 4'b1000;  // AND
        tt[1] = 4'b0111;  // NAND
        tt[2] = 4'b1110;  // OR
        tt[3] = 4'b0001;  // NOR
        tt[4] = 4'b0110;  // XOR
        tt[5] = 4'b1001;  // XNOR
        tt[6] = 4'b0011;  // NOT A
        tt[7] = 4'b0000;

        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("idle");

        run(1, 4, 1, '0, '0, -1);                 // NAND ideal
        run(1, 4, 1, 6'b000100, '0, -1);          // lane 2 stuck at 0
        run(6, 7, 6, '0, '0, 8);                  // NOT, clamp, ignored start
        run(7, 2, 0, '0, '0, -1);                 // invalid type
        run(0, 0, 0, '0, '0, -1);                 // no gates
        run(4, 6, 4, '0, '0, -1);                 // XOR, all lanes
        run(2, 6, 3, '0, '0, -1);                 // wrong IC: all fail
        run(5, 5, 5, 6'b000001, 6'b010000, -1);   // stuck lanes

        // Reset in the middle of a run.
        gt = 3'd1; gc = 3'd4; ic_type = 1; st0 = '0; st1 = '0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("post_rst");
        run(1, 4, 1, '0, '0, -1);

        for (int r = 0; r < 30; r++) begin
            t   = int'($urandom_range(0, 7));
            c   = int'($urandom_range(0, 7));
            ict = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : t;
            s0  = ($urandom_range(0, 2) == 0) ? NG'($urandom) & NG'($urandom) : '0;
            s1  = ($urandom_range(0, 3) == 0) ? NG'($urandom) & NG'($urandom) : '0;
            ign = (c != 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAT - 2)) : -1;
            run(t, c, ict, s0, s1, ign);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
